// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: KSA state encoding, memory/key sizing and key byte selection.
package arc4_pkg;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned KEY_BYTES = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRdI,
    StLdI,
    StRdJ,
    StLdJ,
    StWrI,
    StWrJ
  } ksa_state_t;

  // Byte 0 of the key is the most significant byte.
  function automatic logic [7:0] keybyte_sel(input logic [23:0] key, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = key[23:16];
      2'd1:    b = key[15:8];
      2'd2:    b = key[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling engine: permutes the S memory in place, one swap per 6-cycle iteration.
module ksa #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic                         rdy,
  input  logic [8*KEY_BYTES-1:0]       key,
  output logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [7:0]                   rddata,
  output logic [7:0]                   wrdata,
  output logic                         wren
);

  import arc4_pkg::*;

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] ILast = AW'(MEM_DEPTH - 1);
  localparam logic [1:0]    KLast = 2'(KEY_BYTES - 1);

  ksa_state_t             state_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [AW-1:0]          i_q, j_q;
  logic [1:0]             k_q;
  logic [7:0]             si_q;
  logic                   rdy_q, wren_q;
  logic [AW-1:0]          addr_q;
  logic [7:0]             wrdata_q;
  logic [AW-1:0]          j_d;

  // Running j: add S[i] (arriving on rddata in LD_I) and the current key byte, wrapping.
  always_comb begin
    j_d = j_q + AW'(rddata) + AW'(keybyte_sel(key_q, k_q));
  end

  // Control FSM and datapath; every output is loaded one state ahead so it is registered.
  // wrdata_q latched in LD_J doubles as the sj holding register for WR_I.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      key_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      rdy_q    <= 1'b1;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            key_q   <= key;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            rdy_q   <= 1'b0;
            state_q <= StRdI;
          end
        end
        StRdI: state_q <= StLdI;
        StLdI: begin
          si_q    <= rddata;
          j_q     <= j_d;
          addr_q  <= j_d;
          state_q <= StRdJ;
        end
        StRdJ: state_q <= StLdJ;
        StLdJ: begin
          addr_q   <= i_q;
          wrdata_q <= rddata;
          wren_q   <= 1'b1;
          state_q  <= StWrI;
        end
        StWrI: begin
          addr_q   <= j_q;
          wrdata_q <= si_q;
          state_q  <= StWrJ;
        end
        StWrJ: begin
          wren_q <= 1'b0;
          i_q    <= i_q + 1'b1;
          k_q    <= (k_q == KLast) ? 2'd0 : k_q + 2'd1;
          if (i_q == ILast) begin
            addr_q   <= '0;
            wrdata_q <= '0;
            rdy_q    <= 1'b1;
            state_q  <= StIdle;
          end else begin
            addr_q  <= i_q + 1'b1;
            state_q <= StRdI;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdy    = rdy_q;
  assign wren   = wren_q;
  assign addr   = addr_q;
  assign wrdata = wrdata_q;

endmodule
